hc148_encoder: RTL and testbench
================================

HC148_ENCODER -- requirements
Module: hc148_encoder

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 16, meaning the number of consecutive stable clock cycles needed to accept a new input pattern (legal range 2..65535).
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port ei_n, input, 1 bit: enable input, active-low, asynchronous to clk.
REQ-005 SHALL have port i_n, input, 8 bits: request lines, active-low; i_n[7] is highest priority.
REQ-006 SHALL have port a_n, output, 3 bits: registered 74HC148-style code, active-low.
REQ-007 SHALL have port gs_n, output, 1 bit: group select, low when any request is accepted while enabled.
REQ-008 SHALL have port eo_n, output, 1 bit: enable output, low when enabled and no request is active.
REQ-009 SHALL have port evt_valid, output, 1 bit: a press event is held.
REQ-010 SHALL have port evt_code, output, 3 bits: active-high index of the held event.
REQ-011 SHALL have port evt_ready, input, 1 bit: consumer accepts the event.
REQ-012 SHALL have port ovf, output, 1 bit: sticky flag, event dropped.
REQ-013 SHALL have port ovf_clr, input, 1 bit: clears ovf.

Function
REQ-014 SHALL pass {ei_n, i_n} through a two-flop synchronizer; the result is sync.
REQ-015 SHALL, with debounce compiled in, hold a candidate register cand and a counter.
- If sync differs from cand: cand is loaded from sync and the counter clears.
- Otherwise the counter increments, saturating.
- When the counter equals DEB_CYCLES-1 and sync equals cand, cand is copied to stable on the next edge.
REQ-016 SHALL encode stable into a_n, gs_n and eo_n as follows, with outputs registered one cycle after stable changes:
- ei_n=1: a_n=111, gs_n=1, eo_n=1.
- ei_n=0 and all i_n=1: a_n=111, gs_n=1, eo_n=0.
- Otherwise, with k the highest index for which i_n[k]=0: a_n=~k, gs_n=0, eo_n=1.
REQ-017 SHALL have an end-to-end latency, from an input edge to the output update, of exactly 4+DEB_CYCLES clocks with debounce and 4 clocks without.
REQ-018 SHALL generate a press event on the same edge that the registered gs_n goes from 1 to 0, or that a_n changes while gs_n stays 0; evt_code is ~a_n.
REQ-019 SHALL implement the event buffer as a two-state FSM, EMPTY and FULL; evt_valid=1 exactly in FULL.
- EMPTY with an event: load evt_code, go to FULL.
- FULL with evt_ready=1 and no event: go to EMPTY.
- FULL with evt_ready=1 and an event on the same edge: load the new code, stay FULL, no overflow.
- FULL with evt_ready=0 and an event: keep the old code, drop the new one, set ovf.
REQ-020 SHALL hold evt_code stable while evt_valid=1 and evt_ready=0.
REQ-021 SHALL clear ovf on ovf_clr=1; if ovf_clr and a drop occur on the same edge, the set wins.
REQ-022 SHALL generate no event on a release (gs_n going from 0 to 1) or on ei_n deassertion.
REQ-023 SHALL restart the debounce count on any glitch shorter than DEB_CYCLES; stable and the outputs remain unchanged.

Reset
REQ-024 SHALL on rst_n=0 immediately force:
- sync, cand and stable to all ones; counter to 0;
- a_n=111, gs_n=1, eo_n=1;
- FSM to EMPTY, evt_valid=0, evt_code=000, ovf=0.
REQ-025 SHALL treat reset release as synchronous to clk externally; assertion mid-debounce or mid-handshake discards the pending event.

Configuration
REQ-026 SHALL compile the debounce logic of REQ-015 only when HC148_DEBOUNCE_EN is defined.
REQ-027 SHALL, when HC148_DEBOUNCE_EN is undefined, load stable directly from sync every cycle; DEB_CYCLES is then ignored.

Structure
REQ-028 SHALL place the FSM state enum (EMPTY, FULL), the code width constant (3) and the line count constant (8) in shared package hc148_pkg.
REQ-029 SHALL use one sub-module, hc148_debounce (synchronizer, cand, counter, stable); encoding and the FSM stay in the top module.

Verification
REQ-030 SHALL cover these directed scenarios, with DEB_CYCLES=4 and debounce enabled:
- ei_n=0, i_n=11011111 held -> a_n=010, gs_n=0 exactly 8 clocks after the edge; evt_valid=1, evt_code=5.
- ei_n=0, i_n=01111110 -> a_n=000, evt_code=7 (priority); then i_n=11111111 -> gs_n=1, eo_n=0, no new event.
- i_n pulse low for 3 clocks -> no change on a_n, gs_n or evt_valid.
- evt_ready=0, two distinct presses -> evt_code keeps the first, ovf=1; ovf_clr pulse -> ovf=0.
- evt_ready=1 on the same edge as a new event in FULL -> evt_valid stays 1, new code, ovf=0.
- ei_n=1 with any i_n -> a_n=111, gs_n=1, eo_n=1; rst_n pulse mid-event -> evt_valid=0 immediately.

Source files
------------

// File: rtl/hc148_pkg.sv
// hc148_pkg: shared types and constants for the hc148 encoder slice
// Exports the event buffer state enum (EMPTY, FULL), the code width and the request line count.
package hc148_pkg;
  localparam int CODE_W = 3;
  localparam int LINES = 8;
  typedef enum logic {EMPTY, FULL} evt_state_e;
endpackage

// File: rtl/hc148_if.sv
// hc148_if: request/code/event bundle between the hc148 encoder and its environment
// Ports: ei_n, i_n (active-low enable and requests), a_n/gs_n/eo_n (74HC148 outputs),
// evt_valid/evt_code/evt_ready (press event handshake), ovf/ovf_clr (sticky drop flag).
// slave = the encoder, master = the driver/consumer.
interface hc148_if;
  import hc148_pkg::*;
  logic ei_n;
  logic [LINES-1:0] i_n;
  logic [CODE_W-1:0] a_n;
  logic gs_n;
  logic eo_n;
  logic evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic evt_ready;
  logic ovf;
  logic ovf_clr;
  modport slave (input ei_n, i_n, evt_ready, ovf_clr, output a_n, gs_n, eo_n, evt_valid, evt_code, ovf);
  modport master (output ei_n, i_n, evt_ready, ovf_clr, input a_n, gs_n, eo_n, evt_valid, evt_code, ovf);
endinterface

// File: rtl/hc148_debounce.sv
// hc148_debounce: two-flop synchronizer plus optional debounce producing the stable {ei_n, i_n}
// Ports: clk, rst_n (async active-low), din (raw {ei_n, i_n}), stable (accepted pattern).
// Debounce is compiled only with HC148_DEBOUNCE_EN; otherwise stable follows the synchronizer.
module hc148_debounce import hc148_pkg::*; #(
  parameter int DEB_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [LINES:0] din,
  output logic [LINES:0] stable
);
  logic [LINES:0] meta_q, sync_q, stable_q, stable_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta_q   <= '1;
      sync_q   <= '1;
      stable_q <= '1;
    end else begin
      meta_q   <= din;
      sync_q   <= meta_q;
      stable_q <= stable_d;
    end
`ifdef HC148_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);
  logic [LINES:0] cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cand_q <= '1;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  // cand always tracks sync; the counter measures how long it has been unchanged and
  // saturates at LAST, so any glitch reloads cand and restarts the count.
  always_comb begin
    cand_d   = sync_q;
    cnt_d    = (sync_q != cand_q) ? '0 : (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;
    stable_d = (cnt_q == LAST && sync_q == cand_q) ? cand_q : stable_q;
  end
`else
  localparam int deb_unused = DEB_CYCLES;
  always_comb stable_d = sync_q;
`endif
  assign stable = stable_q;
endmodule

// File: rtl/hc148_encoder.sv
// hc148_encoder: debounced 74HC148-style priority encoder with a one-entry press event buffer
// Ports: clk, rst_n (async active-low), bus (hc148_if.slave: requests in, encoded outputs,
// event handshake and sticky overflow out). Debounce enabled by defining HC148_DEBOUNCE_EN.
module hc148_encoder import hc148_pkg::*; #(
  parameter int DEB_CYCLES = 16
) (
  input logic   clk,
  input logic   rst_n,
  hc148_if.slave bus
);
  logic [LINES:0] stable;
  logic [CODE_W-1:0] a_q, a_d, code_q, code_d;
  logic gs_q, gs_d, eo_q, eo_d, ovf_q, ovf_d, evt, load, drop;
  evt_state_e state_q, state_d;
  hc148_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    ({bus.ei_n, bus.i_n}),
    .stable (stable)
  );
  // Lowest index first so the highest active request overwrites the code.
  always_comb begin
    a_d = '1;
    for (int k = 0; k < LINES; k++) if (!stable[k]) a_d = ~CODE_W'(k);
    if (stable[LINES]) a_d = '1;
    gs_d = stable[LINES] | (&stable[LINES-1:0]);
    eo_d = stable[LINES] | ~(&stable[LINES-1:0]);
  end
  // A press is a new low on gs_n or a code change while gs_n stays low, judged on the
  // values about to be registered so the event lands on the same edge as the outputs.
  always_comb begin
    evt     = !gs_d && (gs_q || a_d != a_q);
    load    = evt && (state_q == EMPTY || bus.evt_ready);
    drop    = evt && state_q == FULL && !bus.evt_ready;
    state_d = load ? FULL : (state_q == FULL && bus.evt_ready) ? EMPTY : state_q;
    code_d  = load ? ~a_d : code_q;
    ovf_d   = drop | (ovf_q & ~bus.ovf_clr);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_q     <= '1;
      gs_q    <= 1'b1;
      eo_q    <= 1'b1;
      state_q <= EMPTY;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      gs_q    <= gs_d;
      eo_q    <= eo_d;
      state_q <= state_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  assign bus.a_n       = a_q;
  assign bus.gs_n      = gs_q;
  assign bus.eo_n      = eo_q;
  assign bus.evt_valid = state_q == FULL;
  assign bus.evt_code  = code_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_hc148_encoder.sv
// tb_hc148_encoder: directed and randomized scoreboard bench for hc148_encoder
module tb_hc148_encoder;
  import hc148_pkg::*;
  localparam int DEB = 4;
`ifdef HC148_DEBOUNCE_EN
  localparam int LAT = 4 + DEB;
  localparam bit DEB_ON = 1'b1;
`else
  localparam int LAT = 4;
  localparam bit DEB_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  hc148_if bus();
  hc148_encoder #(.DEB_CYCLES(DEB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  logic [8:0] hist[$];
  logic [8:0] st_m;
  logic [2:0] a_m;
  logic gs_m, eo_m, ovf_m, ev_m, drop_m;
  logic [4:0] o_m;
  logic [2:0] exp_q[$];
  function automatic logic [4:0] enc(logic [8:0] s);
    if (s[8]) return 5'b11111;
    if (&s[7:0]) return 5'b11110;
    for (int k = 7; k >= 0; k--) if (!s[k]) return {~3'(k), 2'b01};
    return 5'b11111;
  endfunction
  // Pattern is accepted once the last DEB+1 samples agree; hist[DEB] is the sample two edges back.
  function automatic logic [8:0] next_stable();
    logic [8:0] x;
    x = hist[DEB];
    if (!DEB_ON) return x;
    for (int k = 0; k <= DEB; k++) if (hist[k] != x) return st_m;
    return x;
  endfunction
  task automatic model_reset();
    hist = {};
    repeat (DEB + 3) hist.push_back('1);
    st_m = '1;
    a_m = '1;
    gs_m = 1'b1;
    eo_m = 1'b1;
    ovf_m = 1'b0;
    exp_q.delete();
  endtask
  always @(posedge clk) begin
    #1;
    if (!rst_n) model_reset();
    else begin
      hist.push_back({bus.ei_n, bus.i_n});
      void'(hist.pop_front());
      o_m = enc(st_m);
      st_m = next_stable();
      ev_m = !o_m[1] && (gs_m || o_m[4:2] != a_m);
      {a_m, gs_m, eo_m} = o_m;
      drop_m = ev_m && exp_q.size() != 0;
      if (ev_m && !drop_m) exp_q.push_back(~o_m[4:2]);
      ovf_m = drop_m ? 1'b1 : bus.ovf_clr ? 1'b0 : ovf_m;
      chk("a_n", bus.a_n, a_m);
      chk("gs_n", bus.gs_n, gs_m);
      chk("eo_n", bus.eo_n, eo_m);
      chk("evt_valid", bus.evt_valid, exp_q.size() != 0);
      chk("ovf", bus.ovf, ovf_m);
      if (exp_q.size() != 0) chk("evt_code_held", bus.evt_code, exp_q[0]);
    end
  end
  always @(negedge clk)
    if (rst_n && bus.evt_valid && bus.evt_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL evt_unexpected: got code %0d expected no event at %0t", bus.evt_code, $time);
      end else begin
        chk("evt_code_handshake", bus.evt_code, exp_q[0]);
        void'(exp_q.pop_front());
      end
    end
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic drive(logic e, logic [7:0] i);
    bus.ei_n = e;
    bus.i_n = i;
  endtask
  task automatic consume();
    bus.evt_ready = 1'b1;
    step(1);
    bus.evt_ready = 1'b0;
    step(1);
  endtask
  initial begin
    bus.ei_n = 1'b1;
    bus.i_n = '1;
    bus.evt_ready = 1'b0;
    bus.ovf_clr = 1'b0;
    step(3);
    chk("rst_a_n", bus.a_n, 3'b111);
    chk("rst_gs_n", bus.gs_n, 1'b1);
    chk("rst_eo_n", bus.eo_n, 1'b1);
    chk("rst_evt_valid", bus.evt_valid, 1'b0);
    chk("rst_evt_code", bus.evt_code, 3'd0);
    chk("rst_ovf", bus.ovf, 1'b0);
    rst_n = 1'b1;
    step(LAT + 4);
    drive(1'b0, 8'b11011111);
    step(LAT - 1);
    chk("lat_early_gs_n", bus.gs_n, 1'b1);
    step(1);
    chk("lat_a_n", bus.a_n, 3'b010);
    chk("lat_gs_n", bus.gs_n, 1'b0);
    chk("lat_evt_valid", bus.evt_valid, 1'b1);
    chk("lat_evt_code", bus.evt_code, 3'd5);
    consume();
    drive(1'b0, 8'b01111110);
    step(LAT + 2);
    chk("prio_a_n", bus.a_n, 3'b000);
    chk("prio_code", bus.evt_code, 3'd7);
    consume();
    drive(1'b0, 8'hff);
    step(LAT + 2);
    chk("release_gs_n", bus.gs_n, 1'b1);
    chk("release_eo_n", bus.eo_n, 1'b0);
    chk("release_no_evt", bus.evt_valid, 1'b0);
    drive(1'b0, 8'b11110111);
    step(3);
    drive(1'b0, 8'hff);
    step(LAT + 4);
`ifdef HC148_DEBOUNCE_EN
    chk("glitch_gs_n", bus.gs_n, 1'b1);
    chk("glitch_no_evt", bus.evt_valid, 1'b0);
`endif
    consume();
    drive(1'b0, 8'b11111011);
    step(LAT + 2);
    drive(1'b0, 8'b10111111);
    step(LAT + 2);
    chk("ovf_keep_code", bus.evt_code, 3'd2);
    chk("ovf_set", bus.ovf, 1'b1);
    bus.ovf_clr = 1'b1;
    step(1);
    bus.ovf_clr = 1'b0;
    chk("ovf_cleared", bus.ovf, 1'b0);
    drive(1'b0, 8'b11101111);
    step(LAT - 1);
    bus.evt_ready = 1'b1;
    step(1);
    bus.evt_ready = 1'b0;
    chk("same_edge_valid", bus.evt_valid, 1'b1);
    chk("same_edge_code", bus.evt_code, 3'd4);
    chk("same_edge_ovf", bus.ovf, 1'b0);
    consume();
    repeat (4) begin
      drive(1'b1, 8'($urandom));
      step(LAT + 2);
      chk("dis_a_n", bus.a_n, 3'b111);
      chk("dis_gs_n", bus.gs_n, 1'b1);
      chk("dis_eo_n", bus.eo_n, 1'b1);
      chk("dis_no_evt", bus.evt_valid, 1'b0);
    end
    drive(1'b0, 8'b11111101);
    step(LAT + 2);
    chk("pre_rst_valid", bus.evt_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.evt_valid, 1'b0);
    chk("mid_rst_a_n", bus.a_n, 3'b111);
    chk("mid_rst_gs_n", bus.gs_n, 1'b1);
    step(2);
    rst_n = 1'b1;
    step(LAT + 4);
    consume();
    repeat (150) begin
      drive($urandom_range(0, 5) == 0, 8'($urandom));
      repeat ($urandom_range(1, LAT + 4)) begin
        bus.evt_ready = $urandom_range(0, 2) == 0;
        bus.ovf_clr = $urandom_range(0, 7) == 0;
        step(1);
      end
    end
    bus.evt_ready = 1'b0;
    bus.ovf_clr = 1'b0;
    step(LAT + 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
